// File: rtl/button_event_decoder_if.sv
// Event bundle between the debounce stage and the control FSMs.
// slave = decoder side (consumes the level, drives strobes); master = consumer/driver side.
interface button_event_decoder_if;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;
  logic double_pulse;

  modport slave (
    input  btn_level,
    output press_pulse, release_pulse, long_pulse, repeat_pulse, held, double_pulse
  );

  modport master (
    output btn_level,
    input  press_pulse, release_pulse, long_pulse, repeat_pulse, held, double_pulse
  );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/long/repeat one-cycle strobes.
// Optional double-click detection is compiled in with `define DOUBLE_CLICK_EN.
module button_event_decoder #(
  parameter int unsigned HOLD_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000,
  parameter int unsigned DCLICK_CYCLES = 15000000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic                   clk,
  input  logic                   rst_n,
  button_event_decoder_if.slave  evt
);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD, REPEAT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2 || DCLICK_CYCLES < 2) begin : g_param_check
    $error("button_event_decoder: cycle parameters must be at least 2");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_prev_q;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;
  logic             rise, fall;

  assign rise = evt.btn_level & ~btn_prev_q;
  assign fall = ~evt.btn_level & btn_prev_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      PRESSED: begin
        // A fall wins over an expiring counter on the same edge.
        if (fall) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD, REPEAT: begin
        if (fall) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (cnt_q == REPEAT_LAST) begin
          state_d  = REPEAT;
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      btn_prev_q <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      btn_prev_q <= evt.btn_level;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
      held_q     <= held_d;
    end
  end

  assign evt.press_pulse   = press_q;
  assign evt.release_pulse = release_q;
  assign evt.long_pulse    = long_q;
  assign evt.repeat_pulse  = repeat_q;
  assign evt.held          = held_q;

`ifdef DOUBLE_CLICK_EN
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);

  logic             win_open_q, win_open_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic             dbl_press_q, dbl_press_d;
  logic             double_q, double_d;

  always_comb begin
    win_open_d  = win_open_q;
    win_cnt_d   = win_cnt_q;
    dbl_press_d = dbl_press_q;
    double_d    = 1'b0;
    if (win_open_q) begin
      if (win_cnt_q == DCLICK_LAST) win_open_d = 1'b0;
      else                          win_cnt_d  = win_cnt_q + CNT_ONE;
    end
    if (press_d) begin
      double_d    = win_open_q;
      dbl_press_d = win_open_q;
      if (win_open_q) win_open_d = 1'b0;
    end
    // The release closing a double-click press must not arm a triple click.
    if (release_d) begin
      if (!dbl_press_q) begin
        win_open_d = 1'b1;
        win_cnt_d  = '0;
      end
      dbl_press_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_open_q  <= 1'b0;
      win_cnt_q   <= '0;
      dbl_press_q <= 1'b0;
      double_q    <= 1'b0;
    end else begin
      win_open_q  <= win_open_d;
      win_cnt_q   <= win_cnt_d;
      dbl_press_q <= dbl_press_d;
      double_q    <= double_d;
    end
  end

  assign evt.double_pulse = double_q;
`else
  assign evt.double_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed table-driven bench for button_event_decoder (HOLD=8, REPEAT=4, DCLICK=6).
module tb_button_event_decoder;

`ifdef DOUBLE_CLICK_EN
  localparam bit DC = 1'b1;
`else
  localparam bit DC = 1'b0;
`endif

  // exp = {press, release, long, repeat, held, double}
  typedef struct packed {
    logic       btn;
    logic [5:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  vec_t vq[$];

  button_event_decoder_if bif ();

  button_event_decoder #(
    .HOLD_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .DCLICK_CYCLES(6),
    .CNT_W        (26)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .evt  (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] outs();
    return {bif.press_pulse, bif.release_pulse, bif.long_pulse,
            bif.repeat_pulse, bif.held, bif.double_pulse};
  endfunction

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got {p,r,l,rp,h,d}=%b expected %b", name, got, exp);
    end
  endtask

  function automatic void push(input logic b, input logic p, input logic r, input logic l,
                               input logic rp, input logic h, input logic d);
    vq.push_back('{btn: b, exp: {p, r, l, rp, h, d}});
  endfunction

  function automatic void push_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic run_table(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      bif.btn_level = vq[i].btn;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", tag, i), outs(), vq[i].exp);
    end
    vq.delete();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bif.btn_level = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("reset[%0d]", i), outs(), 6'b0);
    end
    rst_n = 1'b1;

    // idle after reset
    push_idle(20);
    // short tap: three cycles pressed
    push(1, 1, 0, 0, 0, 1, 0);
    push(1, 0, 0, 0, 0, 1, 0);
    push(1, 0, 0, 0, 0, 1, 0);
    push(0, 0, 1, 0, 0, 0, 0);
    push_idle(8);
    // long hold: 25 cycles pressed
    for (int k = 0; k < 25; k++)
      push(1, k == 0, 0, k == 8, (k == 12) || (k == 16) || (k == 20) || (k == 24), 1, 0);
    push(0, 0, 1, 0, 0, 0, 0);
    push_idle(8);
    // race: fall on the edge where the hold counter would expire
    for (int k = 0; k < 8; k++) push(1, k == 0, 0, 0, 0, 1, 0);
    push(0, 0, 1, 0, 0, 0, 0);
    push(0, 0, 0, 0, 0, 0, 0);
    push_idle(8);
    // hold into REPEAT before the mid-operation reset
    for (int k = 0; k < 14; k++) push(1, k == 0, 0, k == 8, k == 12, 1, 0);
    run_table("main");

    // reset while in REPEAT with the button still down
    rst_n = 1'b0;
    #1;
    check("rst_async", outs(), 6'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_hold[%0d]", i), outs(), 6'b0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_press", outs(), 6'b100010);
    @(posedge clk);
    #1;
    check("rst_held", outs(), 6'b000010);
    bif.btn_level = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release", outs(), 6'b010000);

    push_idle(8);
    // tap then re-press 3 cycles after release_pulse
    push(1, 1, 0, 0, 0, 1, 0);
    push(1, 0, 0, 0, 0, 1, 0);
    push(0, 0, 1, 0, 0, 0, 0);
    push_idle(2);
    push(1, 1, 0, 0, 0, 1, DC);
    push(1, 0, 0, 0, 0, 1, 0);
    push(0, 0, 1, 0, 0, 0, 0);
    // third quick tap is a plain press
    push_idle(1);
    push(1, 1, 0, 0, 0, 1, 0);
    push(0, 0, 1, 0, 0, 0, 0);
    push_idle(8);
    // re-press 7 cycles after release_pulse: window already closed
    push(1, 1, 0, 0, 0, 1, 0);
    push(0, 0, 1, 0, 0, 0, 0);
    push_idle(6);
    push(1, 1, 0, 0, 0, 1, 0);
    push(0, 0, 1, 0, 0, 0, 0);
    // re-press on the last cycle the window is open
    push_idle(5);
    push(1, 1, 0, 0, 0, 1, DC);
    push(0, 0, 1, 0, 0, 0, 0);
    push_idle(8);
    run_table("dclick");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
